s_pe_ctx_sched: RTL and testbench
=================================

Name: s_pe_ctx_sched

Overview:
Per-PE context scheduler for the streaming PEA. Holds up to N_CTX control words per PE and drives ctrl_pe_o for one s_pe. It steps through the contexts in order, changing context once the PE has produced a programmed number of valid results and its delay pipeline has flushed. This gives time-multiplexed reuse of one PE across consecutive kernel phases without reloading the configuration.

Parameters:
N_CTX, 4, number of context slots (power of 2, >=2)
CFG_W, pea_pkg::N_CFG_BITS_PE, width of one PE control word
CNT_W, 16, iteration counter width
DRAIN_CYCLES, 2, ready-qualified flush cycles between contexts (covers the 2-deep delay-operand pipeline)
NOP_WORD, '0, control word driven when no context is active

Ports:
clk_i  in  1  clock
rst_n_i  in  1  asynchronous active-low reset
cfg_we_i  in  1  context slot write strobe
cfg_addr_i  in  $clog2(N_CTX)  slot index
cfg_ctrl_i  in  CFG_W  control word for the slot
cfg_iter_i  in  CNT_W  valid results to consume in the slot
n_ctx_i  in  $clog2(N_CTX)+1  contexts to run, sampled at start
start_i  in  1  start pulse
abort_i  in  1  synchronous abort
pe_valid_i  in  1  s_pe valid_o
pea_ready_i  in  1  array-wide ready/stall
ctrl_pe_o  out  CFG_W  control word to s_pe
ctx_idx_o  out  $clog2(N_CTX)  active slot
busy_o  out  1  sequence in progress
done_o  out  1  one-cycle completion pulse

Behaviour:
- Reset: FSM=IDLE, ctrl_pe_o=NOP_WORD, ctx_idx_o=0, busy_o=0, done_o=0, counters=0, slot storage=0 (words and iteration counts).
- States: IDLE, RUN, DRAIN, DONE. busy_o=1 in RUN and DRAIN. ctrl_pe_o = slot word in RUN and DRAIN, NOP_WORD in IDLE and DONE. All outputs are registered.
- Config: a write occurs when cfg_we_i=1 in IDLE or DONE. Writes in RUN or DRAIN are dropped.
- IDLE -> start_i=1: latch n_ctx_i (clamp to N_CTX) and set ctx=0.
  - If n_ctx=0, go to DONE next cycle.
  - Otherwise go to RUN with ctrl_pe_o valid on the cycle after start.
- RUN:
  - iter_cnt increments when pe_valid_i && pea_ready_i.
  - When the incrementing beat makes iter_cnt == iter[ctx], go to DRAIN and clear drain_cnt.
  - A slot with iter=0 goes to DRAIN after one cycle in RUN.
- DRAIN:
  - drain_cnt increments only when pea_ready_i=1, and the PE control word is held.
  - At drain_cnt == DRAIN_CYCLES-1 with pea_ready_i=1: if ctx == n_ctx-1, go to DONE; otherwise ctx+1, clear iter_cnt, return to RUN.
- DONE: done_o=1 for exactly one cycle, then IDLE. A start_i in the DONE cycle is ignored.
- start_i in RUN or DRAIN is ignored.
- abort_i=1 in any state: IDLE next cycle, ctrl_pe_o=NOP_WORD, counters cleared, no done pulse. abort_i has priority over start_i and over state transitions. Slot contents are kept.
- Stall: pea_ready_i=0 freezes iter_cnt and drain_cnt. The FSM does not advance except on abort.
- Counter arithmetic is unsigned CNT_W bits and never wraps, because the transition fires on equality.
- Asserting reset mid-sequence returns every register to its reset value on that edge.

Test Plan:
- Load slot0 (word A, iter=3) and slot1 (word B, iter=2), n_ctx=2, start, pea_ready=1, pe_valid high every cycle -> A for 3 cycles + 2 drain cycles, B for 2 + 2, done_o pulses once, then NOP_WORD.
- Same setup with pea_ready low for 4 cycles during the RUN of A and pe_valid held high -> those beats are not counted and the switch to B is delayed by exactly 4 cycles.
- n_ctx=0 start -> busy_o never rises and done_o pulses 2 cycles after start_i.
- cfg_we_i to slot0 during RUN with a new word -> the active word is unchanged, and the next run after DONE uses the original word.
- abort_i asserted during DRAIN with start_i high in the same cycle -> IDLE, NOP_WORD, no done_o; a later start runs from ctx 0.
- Slot1 iter=0 among 3 contexts -> slot1 word is present for 1 RUN cycle + DRAIN_CYCLES, then slot2 runs normally.

Source files
------------

// File: rtl/s_pe_ctx_sched.sv
// Per-PE context scheduler: steps one s_pe through up to N_CTX stored control words,
// advancing after a programmed number of valid results plus a ready-qualified drain.
module s_pe_ctx_sched #(
   parameter int unsigned      N_CTX        = 4,
   parameter int unsigned      CFG_W        = 32,  // matches pea_pkg::N_CFG_BITS_PE
   parameter int unsigned      CNT_W        = 16,
   parameter int unsigned      DRAIN_CYCLES = 2,
   parameter logic [CFG_W-1:0] NOP_WORD     = '0
) (
   input  logic                     clk_i,
   input  logic                     rst_n_i,
   input  logic                     cfg_we_i,
   input  logic [$clog2(N_CTX)-1:0] cfg_addr_i,
   input  logic [CFG_W-1:0]         cfg_ctrl_i,
   input  logic [CNT_W-1:0]         cfg_iter_i,
   input  logic [$clog2(N_CTX):0]   n_ctx_i,
   input  logic                     start_i,
   input  logic                     abort_i,
   input  logic                     pe_valid_i,
   input  logic                     pea_ready_i,
   output logic [CFG_W-1:0]         ctrl_pe_o,
   output logic [$clog2(N_CTX)-1:0] ctx_idx_o,
   output logic                     busy_o,
   output logic                     done_o
);

   localparam int unsigned    AW         = $clog2(N_CTX);
   localparam logic [AW:0]    NCTX_MAX   = (AW+1)'(N_CTX);
   localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYCLES - 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

   state_e            state_q, state_d;
   logic [AW-1:0]     ctx_q, ctx_d;
   logic [AW:0]       n_ctx_q, n_ctx_d;
   logic [CNT_W-1:0]  iter_cnt_q, iter_cnt_d;
   logic [CNT_W-1:0]  drain_cnt_q, drain_cnt_d;
   logic              zero_q, zero_d;
   logic [CFG_W-1:0]  ctrl_q, ctrl_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   logic [CFG_W-1:0]  word_q [N_CTX];
   logic [CNT_W-1:0]  iter_q [N_CTX];

   logic              cfg_open;

   assign cfg_open = (state_q == S_IDLE) || (state_q == S_DONE);

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         for (int unsigned i = 0; i < N_CTX; i++) begin
            word_q[i] <= '0;
            iter_q[i] <= '0;
         end
      end else if (cfg_we_i && cfg_open) begin
         word_q[cfg_addr_i] <= cfg_ctrl_i;
         iter_q[cfg_addr_i] <= cfg_iter_i;
      end
   end

   always_comb begin
      state_d     = state_q;
      ctx_d       = ctx_q;
      n_ctx_d     = n_ctx_q;
      iter_cnt_d  = iter_cnt_q;
      drain_cnt_d = drain_cnt_q;
      zero_d      = 1'b0;

      case (state_q)
         S_IDLE: begin
            // An empty sequence spends one extra IDLE cycle so done lands two cycles after start.
            if (zero_q) begin
               state_d = S_DONE;
            end else if (start_i) begin
               n_ctx_d     = (n_ctx_i > NCTX_MAX) ? NCTX_MAX : n_ctx_i;
               ctx_d       = '0;
               iter_cnt_d  = '0;
               drain_cnt_d = '0;
               if (n_ctx_i == '0) begin
                  zero_d = 1'b1;
               end else begin
                  state_d = S_RUN;
               end
            end
         end
         S_RUN: begin
            if (pea_ready_i) begin
               if (iter_q[ctx_q] == '0) begin
                  state_d     = S_DRAIN;
                  drain_cnt_d = '0;
               end else if (pe_valid_i) begin
                  iter_cnt_d = iter_cnt_q + CNT_W'(1);
                  if (iter_cnt_q + CNT_W'(1) == iter_q[ctx_q]) begin
                     state_d     = S_DRAIN;
                     drain_cnt_d = '0;
                  end
               end
            end
         end
         S_DRAIN: begin
            if (pea_ready_i) begin
               if (drain_cnt_q == DRAIN_LAST) begin
                  drain_cnt_d = '0;
                  if ({1'b0, ctx_q} == n_ctx_q - (AW+1)'(1)) begin
                     state_d = S_DONE;
                  end else begin
                     ctx_d      = ctx_q + AW'(1);
                     iter_cnt_d = '0;
                     state_d    = S_RUN;
                  end
               end else begin
                  drain_cnt_d = drain_cnt_q + CNT_W'(1);
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (abort_i) begin
         state_d     = S_IDLE;
         ctx_d       = '0;
         iter_cnt_d  = '0;
         drain_cnt_d = '0;
         zero_d      = 1'b0;
      end

      busy_d = (state_d == S_RUN) || (state_d == S_DRAIN);
      done_d = (state_d == S_DONE);
      ctrl_d = busy_d ? word_q[ctx_d] : NOP_WORD;
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q     <= S_IDLE;
         ctx_q       <= '0;
         n_ctx_q     <= '0;
         iter_cnt_q  <= '0;
         drain_cnt_q <= '0;
         zero_q      <= 1'b0;
         ctrl_q      <= NOP_WORD;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         ctx_q       <= ctx_d;
         n_ctx_q     <= n_ctx_d;
         iter_cnt_q  <= iter_cnt_d;
         drain_cnt_q <= drain_cnt_d;
         zero_q      <= zero_d;
         ctrl_q      <= ctrl_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign ctrl_pe_o = ctrl_q;
   assign ctx_idx_o = ctx_q;
   assign busy_o    = busy_q;
   assign done_o    = done_q;

endmodule

// File: tb/tb_s_pe_ctx_sched.sv
// Directed bench for s_pe_ctx_sched: per-scenario tasks with inline expected values.
module tb_s_pe_ctx_sched;

   localparam logic [31:0] NOP = 32'h0;
   localparam logic [31:0] WA  = 32'hA0A0_0001;
   localparam logic [31:0] WB  = 32'hB0B0_0002;
   localparam logic [31:0] WC  = 32'hC0C0_0003;
   localparam logic [31:0] WX  = 32'hDEAD_BEEF;

   logic        clk;
   logic        rst_n;
   logic        cfg_we;
   logic [1:0]  cfg_addr;
   logic [31:0] cfg_ctrl;
   logic [15:0] cfg_iter;
   logic [2:0]  n_ctx;
   logic        start;
   logic        abort;
   logic        pe_valid;
   logic        pea_ready;
   logic [31:0] ctrl_pe;
   logic [1:0]  ctx_idx;
   logic        busy;
   logic        done;

   int n_assert = 0;
   int n_fail   = 0;

   s_pe_ctx_sched #(.N_CTX(4), .CFG_W(32), .CNT_W(16), .DRAIN_CYCLES(2), .NOP_WORD(32'h0)) dut (
      .clk_i       (clk),
      .rst_n_i     (rst_n),
      .cfg_we_i    (cfg_we),
      .cfg_addr_i  (cfg_addr),
      .cfg_ctrl_i  (cfg_ctrl),
      .cfg_iter_i  (cfg_iter),
      .n_ctx_i     (n_ctx),
      .start_i     (start),
      .abort_i     (abort),
      .pe_valid_i  (pe_valid),
      .pea_ready_i (pea_ready),
      .ctrl_pe_o   (ctrl_pe),
      .ctx_idx_o   (ctx_idx),
      .busy_o      (busy),
      .done_o      (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic wr_slot(input logic [1:0] a, input logic [31:0] w, input logic [15:0] it);
      cfg_we   = 1'b1;
      cfg_addr = a;
      cfg_ctrl = w;
      cfg_iter = it;
      cyc();
      cfg_we   = 1'b0;
   endtask

   task automatic test_reset();
      n_assert++; if (ctrl_pe !== NOP) begin n_fail++; $display("FAIL reset_ctrl got=%h exp=%h", ctrl_pe, NOP); end
      n_assert++; if (ctx_idx !== 2'd0) begin n_fail++; $display("FAIL reset_ctx got=%0d exp=0", ctx_idx); end
      n_assert++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
      n_assert++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", done); end
   endtask

   task automatic test_two_ctx();
      logic [31:0] ec;
      wr_slot(2'd0, WA, 16'd3);
      wr_slot(2'd1, WB, 16'd2);
      n_ctx = 3'd2; pe_valid = 1'b1; pea_ready = 1'b1; start = 1'b1;
      cyc();
      start = 1'b0;
      for (int i = 0; i < 11; i++) begin
         ec = (i < 5) ? WA : (i < 9) ? WB : NOP;
         n_assert++; if (ctrl_pe !== ec) begin n_fail++; $display("FAIL two_ctx_ctrl c%0d got=%h exp=%h", i+1, ctrl_pe, ec); end
         n_assert++; if (busy !== (i < 9)) begin n_fail++; $display("FAIL two_ctx_busy c%0d got=%b exp=%b", i+1, busy, (i < 9)); end
         n_assert++; if (done !== (i == 9)) begin n_fail++; $display("FAIL two_ctx_done c%0d got=%b exp=%b", i+1, done, (i == 9)); end
         if (i < 9) begin
            n_assert++; if (ctx_idx !== ((i < 5) ? 2'd0 : 2'd1)) begin n_fail++; $display("FAIL two_ctx_idx c%0d got=%0d", i+1, ctx_idx); end
         end
         cyc();
      end
   endtask

   task automatic test_stall();
      logic [31:0] ec;
      n_ctx = 3'd2; pe_valid = 1'b1; pea_ready = 1'b1; start = 1'b1;
      cyc();
      start = 1'b0;
      for (int i = 0; i < 15; i++) begin
         ec = (i < 9) ? WA : (i < 13) ? WB : NOP;
         n_assert++; if (ctrl_pe !== ec) begin n_fail++; $display("FAIL stall_ctrl c%0d got=%h exp=%h", i+1, ctrl_pe, ec); end
         n_assert++; if (done !== (i == 13)) begin n_fail++; $display("FAIL stall_done c%0d got=%b exp=%b", i+1, done, (i == 13)); end
         pea_ready = !(i >= 1 && i <= 4);
         cyc();
      end
      pea_ready = 1'b1;
   endtask

   task automatic test_zero_ctx();
      n_ctx = 3'd0; start = 1'b1;
      cyc();
      start = 1'b0;
      n_assert++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL zero_ctx_c1 got busy=%b done=%b exp 0 0", busy, done); end
      cyc();
      n_assert++; if (busy !== 1'b0 || done !== 1'b1) begin n_fail++; $display("FAIL zero_ctx_c2 got busy=%b done=%b exp 0 1", busy, done); end
      n_assert++; if (ctrl_pe !== NOP) begin n_fail++; $display("FAIL zero_ctx_ctrl got=%h exp=%h", ctrl_pe, NOP); end
      cyc();
      n_assert++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL zero_ctx_c3 got busy=%b done=%b exp 0 0", busy, done); end
   endtask

   task automatic test_cfg_during_run();
      int k;
      n_ctx = 3'd1; start = 1'b1;
      cyc();
      start = 1'b0;
      cfg_we = 1'b1; cfg_addr = 2'd0; cfg_ctrl = WX; cfg_iter = 16'd7;
      cyc();
      cfg_we = 1'b0;
      n_assert++; if (ctrl_pe !== WA) begin n_fail++; $display("FAIL cfg_run_ctrl got=%h exp=%h", ctrl_pe, WA); end
      k = 2;
      while (!done && k < 30) begin cyc(); k++; end
      n_assert++; if (k !== 6) begin n_fail++; $display("FAIL cfg_run_len1 got=%0d exp=6", k); end
      cyc();
      start = 1'b1;
      cyc();
      start = 1'b0;
      n_assert++; if (ctrl_pe !== WA) begin n_fail++; $display("FAIL cfg_rerun_ctrl got=%h exp=%h", ctrl_pe, WA); end
      k = 1;
      while (!done && k < 30) begin cyc(); k++; end
      n_assert++; if (k !== 6) begin n_fail++; $display("FAIL cfg_run_len2 got=%0d exp=6", k); end
      cyc();
   endtask

   task automatic test_abort();
      int  k;
      logic seen_done, seen_busy;
      n_ctx = 3'd2; start = 1'b1;
      cyc();
      start = 1'b0;
      cyc(); cyc(); cyc();
      n_assert++; if (busy !== 1'b1 || ctrl_pe !== WA) begin n_fail++; $display("FAIL abort_pre got busy=%b ctrl=%h exp 1 %h", busy, ctrl_pe, WA); end
      abort = 1'b1; start = 1'b1;
      cyc();
      abort = 1'b0; start = 1'b0;
      n_assert++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy got=%b exp=0", busy); end
      n_assert++; if (ctrl_pe !== NOP) begin n_fail++; $display("FAIL abort_ctrl got=%h exp=%h", ctrl_pe, NOP); end
      n_assert++; if (done !== 1'b0) begin n_fail++; $display("FAIL abort_done got=%b exp=0", done); end
      n_assert++; if (ctx_idx !== 2'd0) begin n_fail++; $display("FAIL abort_ctx got=%0d exp=0", ctx_idx); end
      seen_done = 1'b0; seen_busy = 1'b0;
      for (int i = 0; i < 12; i++) begin
         seen_done |= done; seen_busy |= busy;
         cyc();
      end
      n_assert++; if (seen_done !== 1'b0 || seen_busy !== 1'b0) begin n_fail++; $display("FAIL abort_quiet got done=%b busy=%b exp 0 0", seen_done, seen_busy); end
      start = 1'b1;
      cyc();
      start = 1'b0;
      n_assert++; if (ctrl_pe !== WA || ctx_idx !== 2'd0) begin n_fail++; $display("FAIL abort_restart got ctrl=%h ctx=%0d exp %h 0", ctrl_pe, ctx_idx, WA); end
      k = 1;
      while (!done && k < 30) begin cyc(); k++; end
      n_assert++; if (k !== 10) begin n_fail++; $display("FAIL abort_restart_len got=%0d exp=10", k); end
      cyc();
   endtask

   task automatic test_zero_iter();
      logic [31:0] ec;
      logic [1:0]  ex;
      wr_slot(2'd0, WA, 16'd2);
      wr_slot(2'd1, WB, 16'd0);
      wr_slot(2'd2, WC, 16'd1);
      n_ctx = 3'd3; start = 1'b1;
      cyc();
      start = 1'b0;
      for (int i = 0; i < 11; i++) begin
         ec = (i < 4) ? WA : (i < 7) ? WB : (i < 10) ? WC : NOP;
         ex = (i < 4) ? 2'd0 : (i < 7) ? 2'd1 : 2'd2;
         n_assert++; if (ctrl_pe !== ec) begin n_fail++; $display("FAIL zero_iter_ctrl c%0d got=%h exp=%h", i+1, ctrl_pe, ec); end
         n_assert++; if (done !== (i == 10)) begin n_fail++; $display("FAIL zero_iter_done c%0d got=%b exp=%b", i+1, done, (i == 10)); end
         if (i < 10) begin
            n_assert++; if (ctx_idx !== ex) begin n_fail++; $display("FAIL zero_iter_ctx c%0d got=%0d exp=%0d", i+1, ctx_idx, ex); end
         end
         cyc();
      end
   endtask

   task automatic test_reset_mid_and_clamp();
      int k, busy_cnt;
      n_ctx = 3'd3; start = 1'b1;
      cyc();
      start = 1'b0;
      cyc();
      rst_n = 1'b0;
      #1;
      n_assert++; if (ctrl_pe !== NOP || busy !== 1'b0) begin n_fail++; $display("FAIL rst_mid got ctrl=%h busy=%b exp %h 0", ctrl_pe, busy, NOP); end
      n_assert++; if (ctx_idx !== 2'd0 || done !== 1'b0) begin n_fail++; $display("FAIL rst_mid_ctx got ctx=%0d done=%b exp 0 0", ctx_idx, done); end
      cyc(); cyc();
      rst_n = 1'b1;
      cyc();
      pe_valid = 1'b0; n_ctx = 3'd7; start = 1'b1;
      cyc();
      start = 1'b0;
      k = 1; busy_cnt = 0;
      while (!done && k < 40) begin
         if (busy) busy_cnt++;
         if (k == 10) begin
            n_assert++; if (ctx_idx !== 2'd3 || ctrl_pe !== NOP) begin n_fail++; $display("FAIL clamp_ctx3 got ctx=%0d ctrl=%h exp 3 %h", ctx_idx, ctrl_pe, NOP); end
         end
         cyc(); k++;
      end
      n_assert++; if (k !== 13) begin n_fail++; $display("FAIL clamp_done_cycle got=%0d exp=13", k); end
      n_assert++; if (busy_cnt !== 12) begin n_fail++; $display("FAIL clamp_busy_cycles got=%0d exp=12", busy_cnt); end
      cyc();
   endtask

   initial begin
      rst_n = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_ctrl = '0; cfg_iter = '0;
      n_ctx = '0; start = 1'b0; abort = 1'b0; pe_valid = 1'b0; pea_ready = 1'b1;
      cyc(); cyc();
      test_reset();
      rst_n = 1'b1;
      cyc();
      test_two_ctx();
      test_stall();
      test_zero_ctx();
      test_cfg_during_run();
      test_abort();
      test_zero_iter();
      test_reset_mid_and_clamp();
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
